// File: rtl/mul_div_controller_if.sv
// Command and result bundle between the EX-stage issue logic and mul_div_controller.
// start is a single-cycle request that is accepted only while busy is low.
// While busy is high the unit is occupied and start is ignored.
// hi and lo always show the architectural registers.
interface mul_div_controller_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs_data, rt_data, input busy, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, output busy, hi, lo);
endinterface

// File: rtl/mul_div_controller.sv
// Sequences the shared HI/LO multiply/divide unit: fixed-latency shadow compute, then commit.
// Optional macro MUL_DIV_MADD_EN enables madd/maddu/msub/msubu as accumulate long ops.
module mul_div_controller #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic clk,
    input logic reset,
    mul_div_controller_if.slave bus
);
    typedef enum logic {IDLE, BUSY} stateT;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MUL_DIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    stateT       state;
    logic [3:0]  counter;
    logic [63:0] shadow;
    logic        skipCommit;
    logic [31:0] hiReg;
    logic [31:0] loReg;

    logic        isMul, isDiv, isAcc, isLong, signedOp;
    logic [31:0] opA, opB;
    logic [63:0] product, shadowNext;
    logic        negA, negB;
    logic [31:0] absA, absB, safeB, quoU, remU, quo, rem;

    assign opA = bus.rs_data;
    assign opB = bus.rt_data;

    always_comb begin
        isMul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        isDiv = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`ifdef MUL_DIV_MADD_EN
        isAcc    = (bus.op >= OP_MADD) && (bus.op <= OP_MSUBU);
        signedOp = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`else
        isAcc    = 1'b0;
        signedOp = (bus.op == OP_MULT);
`endif
        isLong = isMul || isDiv || isAcc;
    end

    // Low 64 bits of the sign-extended product equal the true signed product.
    always_comb begin
        if (signedOp)
            product = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
        else
            product = {32'd0, opA} * {32'd0, opB};
    end

    // Signed divide through magnitudes so INT_MIN / -1 wraps to INT_MIN with no trap.
    always_comb begin
        negA  = (bus.op == OP_DIV) && opA[31];
        negB  = (bus.op == OP_DIV) && opB[31];
        absA  = negA ? (~opA + 32'd1) : opA;
        absB  = negB ? (~opB + 32'd1) : opB;
        safeB = (absB == 32'd0) ? 32'd1 : absB;
        quoU  = absA / safeB;
        remU  = absA % safeB;
        quo   = (negA ^ negB) ? (~quoU + 32'd1) : quoU;
        rem   = negA ? (~remU + 32'd1) : remU;
    end

    always_comb begin
        shadowNext = product;
        if (isDiv)
            shadowNext = {rem, quo};
`ifdef MUL_DIV_MADD_EN
        else if (isAcc)
            shadowNext = ((bus.op == OP_MADD) || (bus.op == OP_MADDU))
                       ? ({hiReg, loReg} + product) : ({hiReg, loReg} - product);
`endif
    end

    assign bus.busy = (state == BUSY) || (bus.start && isLong && (state == IDLE));
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= 4'd0;
            shadow     <= 64'd0;
            skipCommit <= 1'b0;
            hiReg      <= 32'd0;
            loReg      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (isLong) begin
                            shadow     <= shadowNext;
                            counter    <= isDiv ? DIV_LOAD : MUL_LOAD;
                            skipCommit <= isDiv && (opB == 32'd0);
                            state      <= BUSY;
                        end else if (bus.op == OP_MTHI) begin
                            hiReg <= opA;
                        end else if (bus.op == OP_MTLO) begin
                            loReg <= opA;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter - 4'd1;
                    // Divide by zero still spends the full latency but leaves HI/LO alone.
                    if (counter == 4'd1) begin
                        if (!skipCommit)
                            {hiReg, loReg} <= shadow;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_controller.sv
// Self-checking bench for mul_div_controller: directed vector table, corner sequences, random ops.
module tb_mul_div_controller;
    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 10;

    logic clk = 1'b0;
    logic reset;
    mul_div_controller_if bus();

    mul_div_controller #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] mhi, mlo;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          nb;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int busy_cycles(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return MUL_CYCLES + 1;
        if (op == 4'd3 || op == 4'd4) return DIV_CYCLES + 1;
`ifdef MUL_DIV_MADD_EN
        if (op >= 4'd7 && op <= 4'd10) return MUL_CYCLES + 1;
`endif
        return 0;
    endfunction

    // Architectural result from plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = acc;
        case (op)
            4'd1: r = sa * sb;
            4'd2: r = ua * ub;
            4'd3: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            4'd4: if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
            4'd5: r = {a, acc[31:0]};
            4'd6: r = {acc[63:32], a};
`ifdef MUL_DIV_MADD_EN
            4'd7:  r = acc + 64'(sa * sb);
            4'd8:  r = acc + ua * ub;
            4'd9:  r = acc - 64'(sa * sb);
            4'd10: r = acc - ua * ub;
`endif
            default: r = acc;
        endcase
        return r;
    endfunction

    // Issue one command and check busy and HI/LO on every cycle until the result shows.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int nb);
        int vis;
        logic [63:0] old, e;
        vis = (nb > 0) ? nb : 1;
        old = {mhi, mlo};
        exp_q.push_back(exp);
        bus.start = 1'b1;
        bus.op = op;
        bus.rs_data = a;
        bus.rt_data = b;
        for (int k = 0; k <= vis; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", name, k), {63'd0, bus.busy}, {63'd0, k < nb});
            if (k < vis) begin
                chk($sformatf("%s hold c%0d", name, k), {bus.hi, bus.lo}, old);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s result", name), {bus.hi, bus.lo}, e);
            end
            @(posedge clk);
            #1;
            if (k == 0) bus.start = 1'b0;
        end
        {mhi, mlo} = exp;
    endtask

    initial begin
        vecs[0]  = '{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYCLES + 1};
        vecs[1]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES + 1};
        vecs[2]  = '{4'd4,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DIV_CYCLES + 1};
        vecs[3]  = '{4'd5,  32'h00000011, 32'd0,        32'h00000011, 32'h7FFFFFFC, 0};
        vecs[4]  = '{4'd6,  32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[5]  = '{4'd3,  32'd5,        32'd0,        32'h00000011, 32'h00000022, DIV_CYCLES + 1};
        vecs[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYCLES + 1};
        vecs[7]  = '{4'd0,  32'd5,        32'd7,        32'h00000000, 32'h80000000, 0};
        vecs[8]  = '{4'd13, 32'd5,        32'd7,        32'h00000000, 32'h80000000, 0};
        vecs[9]  = '{4'd5,  32'd0,        32'd0,        32'h00000000, 32'h80000000, 0};
        vecs[10] = '{4'd6,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0};
`ifdef MUL_DIV_MADD_EN
        vecs[11] = '{4'd7,  32'd1,        32'd1,        32'h00000001, 32'h00000000, MUL_CYCLES + 1};
`else
        vecs[11] = '{4'd7,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0};
`endif
        vecs[12] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYCLES + 1};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 4'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        mhi = 32'd0;
        mlo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++)
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                  {vecs[i].exp_hi, vecs[i].exp_lo}, vecs[i].nb);

        // mthi issued while a mult is in flight must be ignored.
        bus.start = 1'b1;
        bus.op = 4'd1;
        bus.rs_data = 32'd7;
        bus.rt_data = 32'd6;
        for (int k = 0; k <= MUL_CYCLES + 1; k++) begin
            @(negedge clk);
            chk($sformatf("ignore busy c%0d", k), {63'd0, bus.busy}, {63'd0, k <= MUL_CYCLES});
            if (k <= MUL_CYCLES)
                chk($sformatf("ignore hold c%0d", k), {bus.hi, bus.lo}, {mhi, mlo});
            else
                chk("ignore result", {bus.hi, bus.lo}, 64'd42);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (k == 1) begin
                bus.start = 1'b1;
                bus.op = 4'd5;
                bus.rs_data = 32'h0000ABCD;
            end
        end
        @(negedge clk);
        chk("ignore after", {bus.hi, bus.lo}, 64'd42);
        {mhi, mlo} = 64'd42;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            issue($sformatf("rand%0d op%0d", i, op), op, a, b, model(op, a, b, {mhi, mlo}),
                  busy_cycles(op));
        end

        // Asynchronous reset in the middle of a multu discards the result.
        issue("pre-reset mthi", 4'd5, 32'h5, 32'd0, model(4'd5, 32'h5, 32'd0, {mhi, mlo}), 0);
        bus.start = 1'b1;
        bus.op = 4'd2;
        bus.rs_data = 32'hFFFFFFFF;
        bus.rt_data = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midreset busy c%0d", k), {63'd0, bus.busy}, 64'd1);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        chk("midreset busy drop", {63'd0, bus.busy}, 64'd0);
        chk("midreset hilo drop", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (MUL_CYCLES + 3) @(posedge clk);
        @(negedge clk);
        chk("midreset no commit busy", {63'd0, bus.busy}, 64'd0);
        chk("midreset no commit hilo", {bus.hi, bus.lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
